ctrl_decode_pipe: RTL and testbench

Registered instruction-control decoder for the 4-stage CPU, generalised from the single-register decode stage. Maps opcode/func to the ALU operation and datapath control bundle. Carries an opaque instruction payload alongside. Uses a 2-entry skid buffer with valid/ready handshakes on both sides, plus synchronous flush and illegal-opcode detection and counting. Sits between fetch (upstream) and register-read/execute (downstream).

---
 rtl/ctrl_decode_pipe_if.sv | 32 +++
 rtl/ctrl_decode_pipe.sv | 114 +++++++++++
 tb/tb_ctrl_decode_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_decode_pipe_if.sv
// Handshake bundle between fetch, the control decoder and register-read/execute.
// slave is the decoder's view; master is the view of whatever drives and consumes it.
interface ctrl_decode_pipe_if #(
  parameter int OP_W     = 4,
  parameter int FN_W     = 4,
  parameter int ALU_OP_W = 6,
  parameter int PAY_W    = 32,
  parameter int CNT_W    = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     opcode;
  logic [FN_W-1:0]     func;
  logic [PAY_W-1:0]    in_payload;
  logic                out_valid;
  logic                out_ready;
  logic [ALU_OP_W-1:0] ctrl_alu_op;
  logic [6:0]          ctrl_bundle;
  logic [PAY_W-1:0]    out_payload;
  logic                illegal;
  logic [CNT_W-1:0]    illegal_cnt;

  modport slave (
    input  in_valid, opcode, func, in_payload, out_ready,
    output in_ready, out_valid, ctrl_alu_op, ctrl_bundle, out_payload, illegal, illegal_cnt
  );

  modport master (
    output in_valid, opcode, func, in_payload, out_ready,
    input  in_ready, out_valid, ctrl_alu_op, ctrl_bundle, out_payload, illegal, illegal_cnt
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Registered opcode/func -> ALU op + control bundle decoder, 1-cycle latency.
// Two-entry skid (output reg + skid reg); in_ready is registered as !skid_valid.
module ctrl_decode_pipe #(
  parameter int OP_W       = 4,
  parameter int FN_W       = 4,
  parameter int ALU_OP_W   = 6,
  parameter int CMP_BASE   = 16,
  parameter int JAL_ALU_OP = 32,
  parameter int PAY_W      = 32,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  ctrl_decode_pipe_if.slave   bus
);
  localparam logic [OP_W-1:0] OP_ALUR   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_CMPR   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SW     = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ALUI   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_LW     = OP_W'(9);
  localparam logic [OP_W-1:0] OP_CMPI   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_JAL    = OP_W'(11);

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [6:0]          bundle;
    logic                illegal;
    logic [PAY_W-1:0]    payload;
  } entry_t;

  entry_t           out_q, out_d, skid_q, skid_d, dec;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up, down;
  logic [ALU_OP_W-1:0] func_ext, cmp_op;

  assign func_ext = ALU_OP_W'(bus.func);
  assign cmp_op   = ALU_OP_W'(CMP_BASE) + func_ext;

  always_comb begin
    dec         = '0;
    dec.payload = bus.in_payload;
    case (bus.opcode)
      OP_ALUR:   begin dec.alu_op = func_ext;               dec.bundle = 7'b0000001; end
      OP_ALUI:   begin dec.alu_op = func_ext;               dec.bundle = 7'b0000011; end
      OP_LW:     begin dec.alu_op = func_ext;               dec.bundle = 7'b0101011; end
      OP_SW:     begin dec.alu_op = func_ext;               dec.bundle = 7'b0000110; end
      OP_CMPR:   begin dec.alu_op = cmp_op;                 dec.bundle = 7'b0000001; end
      OP_CMPI:   begin dec.alu_op = cmp_op;                 dec.bundle = 7'b0000011; end
      OP_BRANCH: begin dec.alu_op = cmp_op;                 dec.bundle = 7'b0010000; end
      OP_JAL:    begin dec.alu_op = ALU_OP_W'(JAL_ALU_OP);  dec.bundle = 7'b1010011; end
      default:   dec.illegal = 1'b1;
    endcase
  end

  assign up   = bus.in_valid && !skid_valid_q;
  assign down = out_valid_q && bus.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (flush) begin
      // Anything presented alongside a flush is dropped and not counted.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (up && dec.illegal && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
      if (!out_valid_q || down) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end else if (up) begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (up) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.ctrl_alu_op = out_q.alu_op;
  assign bus.ctrl_bundle = out_q.bundle;
  assign bus.out_payload = out_q.payload;
  assign bus.illegal     = out_q.illegal;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: decode table, skid ordering, flush, illegal counting.
module tb_ctrl_decode_pipe;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] ALUR = 4'd0, CMPR = 4'd2, SW = 4'd5, BRANCH = 4'd6;
  localparam logic [3:0] ALUI = 4'd8, LW = 4'd9, CMPI = 4'd10, JAL = 4'd11, BAD = 4'd15;

  ctrl_decode_pipe_if #(.CNT_W(16)) bus ();
  ctrl_decode_pipe_if #(.CNT_W(2))  sbus ();

  ctrl_decode_pipe #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  ctrl_decode_pipe #(.CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (sbus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] fn, input logic [31:0] pay);
    bus.in_valid   = 1'b1;
    bus.opcode     = op;
    bus.func       = fn;
    bus.in_payload = pay;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] alu, input logic [6:0] bnd,
                            input logic [31:0] pay);
    check({tag, ".vld"}, bus.out_valid, 1'b1);
    check({tag, ".alu"}, bus.ctrl_alu_op, alu);
    check({tag, ".bnd"}, bus.ctrl_bundle, bnd);
    check({tag, ".pay"}, bus.out_payload, pay);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.opcode = '0; bus.func = '0; bus.in_payload = '0; bus.out_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.opcode = '0; sbus.func = '0; sbus.in_payload = '0; sbus.out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst.vld", bus.out_valid, 1'b0);
    check("rst.rdy", bus.in_ready, 1'b1);
    check("rst.alu", bus.ctrl_alu_op, 6'd0);
    check("rst.bnd", bus.ctrl_bundle, 7'd0);
    check("rst.pay", bus.out_payload, 32'd0);
    check("rst.ill", bus.illegal, 1'b0);
    check("rst.cnt", bus.illegal_cnt, 16'd0);

    // Streaming, one per cycle
    bus.out_ready = 1'b1;
    drive(ALUR, 4'd3, 32'h11); tick(); expect_out("alur", 6'd3, 7'b0000001, 32'h11);
    drive(LW, 4'd0, 32'h22);   tick(); expect_out("lw", 6'd0, 7'b0101011, 32'h22);
    drive(JAL, 4'd7, 32'h33);  tick(); expect_out("jal", 6'd32, 7'b1010011, 32'h33);
    drive(CMPI, 4'd5, 32'h44); tick(); expect_out("cmpi", 6'd21, 7'b0000011, 32'h44);
    drive(BRANCH, 4'd15, 32'h55); tick(); expect_out("br", 6'd31, 7'b0010000, 32'h55);
    check("br.ill", bus.illegal, 1'b0);
    drive(CMPR, 4'd1, 32'h66); tick(); expect_out("cmpr", 6'd17, 7'b0000001, 32'h66);
    drive(SW, 4'd9, 32'h77);   tick(); expect_out("sw", 6'd9, 7'b0000110, 32'h77);
    bus.in_valid = 1'b0; tick();
    check("idle.vld", bus.out_valid, 1'b0);

    // Skid: A held, B skidded, C refused, then drained in order
    bus.out_ready = 1'b0;
    drive(ALUR, 4'd1, 32'hA); tick();
    expect_out("skA", 6'd1, 7'b0000001, 32'hA);
    check("skA.rdy", bus.in_ready, 1'b1);
    drive(ALUI, 4'd2, 32'hB); tick();
    expect_out("skA2", 6'd1, 7'b0000001, 32'hA);
    check("skB.rdy", bus.in_ready, 1'b0);
    drive(SW, 4'd4, 32'hC); tick();
    expect_out("skA3", 6'd1, 7'b0000001, 32'hA);
    check("skC.rdy", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1; tick();
    expect_out("drB", 6'd2, 7'b0000011, 32'hB);
    check("drB.rdy", bus.in_ready, 1'b1);
    tick();
    expect_out("drC", 6'd4, 7'b0000110, 32'hC);
    bus.in_valid = 1'b0; tick();
    check("drEnd.vld", bus.out_valid, 1'b0);

    // Illegal opcodes
    drive(BAD, 4'd0, 32'hDEADBEEF); tick();
    expect_out("ill", 6'd0, 7'd0, 32'hDEADBEEF);
    check("ill.flag", bus.illegal, 1'b1);
    check("ill.cnt1", bus.illegal_cnt, 16'd1);
    drive(4'd1, 4'd0, 32'h1); tick();
    check("ill.cnt2", bus.illegal_cnt, 16'd2);
    check("ill.flag2", bus.illegal, 1'b1);
    bus.in_valid = 1'b0; tick();

    // Flush with full skid and an illegal opcode on the input
    bus.out_ready = 1'b0;
    drive(ALUR, 4'd1, 32'h1); tick();
    drive(ALUR, 4'd2, 32'h2); tick();
    check("fl.pre.rdy", bus.in_ready, 1'b0);
    drive(BAD, 4'd0, 32'h3); flush = 1'b1; tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("fl.vld", bus.out_valid, 1'b0);
    check("fl.rdy", bus.in_ready, 1'b1);
    check("fl.cnt", bus.illegal_cnt, 16'd2);

    // Flush while in_ready=1: the illegal opcode must not be counted or skidded
    drive(ALUR, 4'd1, 32'h4); tick();
    drive(BAD, 4'd0, 32'h5); flush = 1'b1; tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("fl2.vld", bus.out_valid, 1'b0);
    check("fl2.rdy", bus.in_ready, 1'b1);
    check("fl2.cnt", bus.illegal_cnt, 16'd2);
    tick();
    check("fl2.after.vld", bus.out_valid, 1'b0);

    // Saturation on the CNT_W=2 instance
    sbus.out_ready = 1'b1;
    sbus.in_valid = 1'b1; sbus.opcode = BAD; sbus.func = '0; sbus.in_payload = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat.%0d", i), sbus.illegal_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
    end
    sbus.in_valid = 1'b0;

    // Reset and flush together with a full skid
    bus.out_ready = 1'b0;
    drive(BAD, 4'd0, 32'h9); tick();
    check("rf.cnt", bus.illegal_cnt, 16'd3);
    drive(LW, 4'd3, 32'h8); tick();
    check("rf.pre.rdy", bus.in_ready, 1'b0);
    reset = 1'b1; flush = 1'b1; tick();
    reset = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    check("rf.vld", bus.out_valid, 1'b0);
    check("rf.rdy", bus.in_ready, 1'b1);
    check("rf.alu", bus.ctrl_alu_op, 6'd0);
    check("rf.bnd", bus.ctrl_bundle, 7'd0);
    check("rf.pay", bus.out_payload, 32'd0);
    check("rf.ill", bus.illegal, 1'b0);
    check("rf.cnt0", bus.illegal_cnt, 16'd0);
    check("rf.scnt0", sbus.illegal_cnt, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
